// File: rtl/window_stream_gen_if.sv
// ---------------------------------------------------------------------------
// window_stream_gen_if
//
// Bundles the pixel-input and window-output handshakes of window_stream_gen.
//
// Parameters : DATA_W pixel width, IMG_W pixels per line, WIN window edge,
//              CNT_W window counter width.
// Signals    : pixel / pixel_valid / pixel_ready     raster-order input stream
//              window / window_valid / window_ready  WIN x WIN window stream
//              window_col                            column of element c=0
//              window_count                          windows transferred
// Modports   : master - the window generator
//              slave  - the surrounding environment (source and sink)
// ---------------------------------------------------------------------------
interface window_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 480,
  parameter int WIN    = 6,
  parameter int CNT_W  = 32
);
  localparam int COL_W = $clog2(IMG_W);

  logic [DATA_W-1:0]         pixel;
  logic                      pixel_valid;
  logic                      pixel_ready;
  logic [WIN*WIN*DATA_W-1:0] window;
  logic                      window_valid;
  logic                      window_ready;
  logic [COL_W-1:0]          window_col;
  logic [CNT_W-1:0]          window_count;

  modport master (
    input  pixel, pixel_valid, window_ready,
    output pixel_ready, window, window_valid, window_col, window_count
  );

  modport slave (
    output pixel, pixel_valid, window_ready,
    input  pixel_ready, window, window_valid, window_col, window_count
  );
endinterface

// File: rtl/window_stream_gen.sv
// ---------------------------------------------------------------------------
// window_stream_gen
//
// Sliding-window generator. Raster-order pixels are written into a ring of
// WIN+1 line buffers; once WIN complete lines are held, a two-state read FSM
// sweeps each output row and loads one WIN x WIN window per output handshake
// into a registered output stage. The extra line buffer lets the next line
// fill while the current row of windows is being read out.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high; clears all state including window data
//   flush  - synchronous clear of pointers, fill level, counter and valid;
//            line-buffer contents are left as they are
//   ws     - window_stream_gen_if.master:
//            pixel/pixel_valid/pixel_ready    input stream
//            window/window_valid/window_ready output stream
//            window_col                       column of element c=0
//            window_count                     windows transferred (wraps)
//
// Window packing: element [r][c] lives at bits ((r*WIN+c)*DATA_W) +: DATA_W,
// r=0 is the oldest (top) line, c=0 the leftmost column.
// ---------------------------------------------------------------------------
module window_stream_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 480,
  parameter int WIN    = 6,
  parameter int CNT_W  = 32
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  window_stream_gen_if.master ws
);

  localparam int NUM_LB   = WIN + 1;
  localparam int COL_W    = $clog2(IMG_W);
  localparam int LB_W     = $clog2(NUM_LB);
  localparam int LF_W     = $clog2(NUM_LB + 1);
  localparam int WIN_BITS = WIN * WIN * DATA_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] RD_LAST  = COL_W'(IMG_W - WIN);
  localparam logic [LB_W-1:0]  LB_LAST  = LB_W'(NUM_LB - 1);
  localparam logic [LF_W-1:0]  LF_FULL  = LF_W'(NUM_LB);
  localparam logic [LF_W-1:0]  LF_WIN   = LF_W'(WIN);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Ring index (base + off) mod NUM_LB; off is always < NUM_LB, so a single
  // conditional subtract is enough and works for any ring size.
  function automatic logic [LB_W-1:0] lb_add(input logic [LB_W-1:0] base,
                                             input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_LB) sum = sum - NUM_LB;
    return LB_W'(sum);
  endfunction

  // Line-buffer storage (no reset: contents survive flush by design)
  logic [DATA_W-1:0] lb_mem_q [NUM_LB][IMG_W];

  // Write side
  logic [COL_W-1:0]    wr_col_q;
  logic [LB_W-1:0]     wr_lb_q;
  logic [LF_W-1:0]     lines_full_q;
  logic [LF_W-1:0]     lines_full_d;

  // Read side / FSM
  state_t              state_q;
  logic [COL_W-1:0]    rd_col_q;
  logic [LB_W-1:0]     rd_lb_q;

  // Output register
  logic [WIN_BITS-1:0] win_q;
  logic [WIN_BITS-1:0] win_gather;
  logic [COL_W-1:0]    win_col_q;
  logic                win_vld_q;
  logic [CNT_W-1:0]    win_cnt_q;

  // Handshake qualifiers
  logic pix_rdy;
  logic in_xfer;
  logic line_done;
  logic out_xfer;
  logic load;
  logic row_end;

  // pixel_ready depends only on registered fill state plus reset/flush, so
  // there is no combinational path from window_ready to pixel_ready.
  assign pix_rdy   = !reset && !flush && (lines_full_q < LF_FULL);
  assign in_xfer   = ws.pixel_valid && pix_rdy;
  assign line_done = in_xfer && (wr_col_q == COL_LAST);
  assign out_xfer  = win_vld_q && ws.window_ready;
  assign load      = (state_q == S_EMIT) && (!win_vld_q || ws.window_ready);
  assign row_end   = load && (rd_col_q == RD_LAST);

  // A line completing and a line retiring in the same cycle cancel out.
  always_comb begin
    lines_full_d = lines_full_q;
    if (line_done && !row_end) begin
      lines_full_d = lines_full_q + LF_W'(1);
    end else if (!line_done && row_end) begin
      lines_full_d = lines_full_q - LF_W'(1);
    end
  end

  // ---- stage p0: line-buffer write ----
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb_mem_q[wr_lb_q][wr_col_q] <= ws.pixel;
    end
  end

  // ---- stage p0: window gather from the WIN oldest lines ----
  // Written lines never alias the lines being read: while emitting,
  // wr_lb is rd_lb + WIN (mod NUM_LB), the one spare buffer.
  always_comb begin
    win_gather = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_gather[(r*WIN+c)*DATA_W +: DATA_W] =
          lb_mem_q[lb_add(rd_lb_q, r)][rd_col_q + COL_W'(c)];
      end
    end
  end

  // ---- stage p0 -> p1: pointers, fill level, read FSM, valid, counter ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_col_q     <= '0;
      wr_lb_q      <= '0;
      rd_col_q     <= '0;
      rd_lb_q      <= '0;
      lines_full_q <= '0;
      state_q      <= S_IDLE;
      win_vld_q    <= 1'b0;
      win_cnt_q    <= '0;
    end else begin
      if (in_xfer) begin
        if (wr_col_q == COL_LAST) begin
          wr_col_q <= '0;
          wr_lb_q  <= (wr_lb_q == LB_LAST) ? '0 : wr_lb_q + LB_W'(1);
        end else begin
          wr_col_q <= wr_col_q + COL_W'(1);
        end
      end

      lines_full_q <= lines_full_d;

      case (state_q)
        S_IDLE: begin
          if (lines_full_q >= LF_WIN) state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (load) begin
            if (rd_col_q == RD_LAST) begin
              // Row finished: retire the oldest line and decide on the
              // post-update fill so the next row starts without a bubble.
              rd_col_q <= '0;
              rd_lb_q  <= (rd_lb_q == LB_LAST) ? '0 : rd_lb_q + LB_W'(1);
              if (lines_full_d < LF_WIN) state_q <= S_IDLE;
            end else begin
              rd_col_q <= rd_col_q + COL_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (load) begin
        win_vld_q <= 1'b1;
      end else if (out_xfer) begin
        win_vld_q <= 1'b0;
      end

      if (out_xfer) win_cnt_q <= win_cnt_q + CNT_W'(1);
    end
  end

  // ---- stage p1: output window register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q     <= '0;
      win_col_q <= '0;
    end else if (load && !flush) begin
      win_q     <= win_gather;
      win_col_q <= rd_col_q;
    end
  end

  assign ws.pixel_ready  = pix_rdy;
  assign ws.window       = win_q;
  assign ws.window_valid = win_vld_q;
  assign ws.window_col   = win_col_q;
  assign ws.window_count = win_cnt_q;

endmodule

// File: doc/window_stream_gen.md
# window_stream_gen

Parametrised sliding-window generator for the streaming corner-detection pipeline. It sits between the pixel source and the gradient/response stages. It buffers raster-order pixels in a ring of WIN+1 line buffers and emits one WIN×WIN window per accepted output handshake. Unlike the fixed 6×6 / 480-column generator, geometry and pixel width are parameters. Both sides use ready/valid flow control, and the block adds flush, window coordinates and a window counter.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 480, pixels per line (≥ WIN+1)
- WIN, 6, window edge (≥ 2); NUM_LB = WIN+1 line buffers (derived localparam)
- CNT_W, 32, window_count width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of pointers/fill state; buffer RAM contents untouched
- pixel  in  DATA_W  input pixel, raster order
- pixel_valid  in  1  pixel present
- pixel_ready  out  1  block can accept pixel; transfer when pixel_valid & pixel_ready
- window  out  WIN*WIN*DATA_W  element [r][c] at bits ((r*WIN+c)*DATA_W) +: DATA_W; r=0 oldest (top) line, c=0 leftmost
- window_valid  out  1  window register holds an unconsumed window
- window_ready  in  1  downstream accepts; transfer when window_valid & window_ready
- window_col  out  $clog2(IMG_W)  column of window element c=0
- window_count  out  CNT_W  windows transferred since reset/flush, wraps modulo 2^CNT_W

## Operation
- Write side: wr_col counts 0..IMG_W-1 on each input transfer. On the transfer at wr_col=IMG_W-1, wr_col goes to 0 and wr_lb goes to (wr_lb+1) mod NUM_LB. The same transfer increments lines_full.
- pixel_ready = !reset & !flush & (lines_full < NUM_LB). It is derived from registered state only; there is no combinational path from window_ready.
- Read FSM has two states.
  - IDLE → EMIT when lines_full ≥ WIN.
  - In EMIT, rd_col steps 0..IMG_W-WIN, one step per window load. Window row r reads line buffer (rd_lb+r) mod NUM_LB at columns rd_col..rd_col+WIN-1.
  - After the load at rd_col=IMG_W-WIN: rd_lb advances by 1 mod NUM_LB, lines_full decrements (retire oldest line), rd_col returns to 0.
  - The FSM then stays in EMIT if lines_full (post-update) ≥ WIN, else goes to IDLE.
- Simultaneous line-complete write and retire in the same cycle: lines_full unchanged.
- Output register:
  - Loads a new window when the FSM is in EMIT and (!window_valid | window_ready).
  - Otherwise window, window_col and window_valid hold.
  - window_valid clears on a transfer with no new load.
- window_count increments on each output transfer.
- Arithmetic: all pointer wraps are explicit compares, not power-of-two masks. No pixel data is modified.
- flush, when high: wr_col, wr_lb, rd_col, rd_lb, lines_full, window_count and window_valid go to 0; the FSM goes to IDLE. An in-flight window is dropped, and an input pixel in that cycle is not accepted.
- reset has the same effect as flush. reset outranks everything, including mid-line and mid-row.

## Timing
- Reset values: pixel_ready=0 during reset, 1 the cycle after; window_valid=0, window=0, window_col=0, window_count=0; FSM=IDLE.
- Latency: first window_valid rises on the 2nd rising edge after the input transfer that completes line WIN-1 of a frame.
  - Edge 1: lines_full=WIN, FSM→EMIT.
  - Edge 2: window loaded.
- Throughput: one window per cycle while window_ready=1 and lines_full ≥ WIN. There are no bubbles within a row or at row boundaries when the next row's lines are already full.
- Backpressure: while window_valid & !window_ready, window/window_col remain stable and rd_col does not advance.
- Full condition: lines_full=NUM_LB drops pixel_ready the cycle after the completing transfer. pixel_ready re-rises the cycle after the retiring load.
- Per frame, (IMG_W-WIN+1) windows are emitted per output row.

## Test plan
- Ramp fill, IMG_W=8, WIN=3, pixel=(line*16+col), window_ready=1:
  - first window_valid exactly 2 cycles after pixel 23 is accepted;
  - windows 0..5 have window_col 0..5;
  - window 0 is [[0,1,2],[16,17,18],[32,33,34]].
- Default params, 10 lines, window_ready=1 → window_count=(10-5)*475=2375; no gap cycles between valid windows once line 6 is complete.
- Output stall: hold window_ready=0 for 20 cycles mid-row, pixel_valid=1 → window stable; pixel_ready falls once lines_full=NUM_LB; after release, windows resume in order with no skipped/duplicated window_col.
- Ring wrap, IMG_W=8, WIN=3, 12 lines → the row-9 window rows come from line buffers 1,2,3 (mod 4), and contents match the ramp.
- Mid-row flush at window_col=3 → next cycle window_valid=0, window_count=0, pixel_ready=1; refill produces the first window after 3 new lines with correct contents.
- Random pixel_valid/window_ready (50% each), 3 frames, IMG_W=8, WIN=3, compared against a reference model → no mismatches; pixel_ready never 1 while lines_full=NUM_LB.
